// File: rtl/io_stim_pkg.sv
// io_stim_pkg: shared types and constants for the io_stim_sequencer slice.
// Holds the FSM state enum, pattern mode codes, config word field offsets,
// the per-mode seed values and the helpers that seed and advance a pattern.
package io_stim_pkg;

   localparam int CFG_W = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] MODE_STATIC = 4'd0;
   localparam logic [3:0] MODE_COUNT  = 4'd1;
   localparam logic [3:0] MODE_WALK   = 4'd2;
   localparam logic [3:0] MODE_TOGGLE = 4'd3;

   localparam int MASK_LSB  = 0;
   localparam int DIV_LSB   = 8;
   localparam int MODE_LSB  = 16;
   localparam int STEPS_LSB = 20;

   localparam logic [7:0] SEED_STATIC = 8'hFF;
   localparam logic [7:0] SEED_COUNT  = 8'h00;
   localparam logic [7:0] SEED_WALK   = 8'h01;
   localparam logic [7:0] SEED_TOGGLE = 8'h55;

   // Starting pattern for a mode; unknown modes fall back to static.
   function automatic logic [7:0] modeSeed(input logic [3:0] mode);
      logic [7:0] seed;
      case (mode)
         MODE_COUNT:  seed = SEED_COUNT;
         MODE_WALK:   seed = SEED_WALK;
         MODE_TOGGLE: seed = SEED_TOGGLE;
         default:     seed = SEED_STATIC;
      endcase
      return seed;
   endfunction

   // Pattern after one step; static and unknown modes hold their value.
   function automatic logic [7:0] modeAdvance(input logic [3:0] mode, input logic [7:0] pat);
      logic [7:0] nxt;
      case (mode)
         MODE_COUNT:  nxt = pat + 8'd1;
         MODE_WALK:   nxt = {pat[6:0], pat[7]};
         MODE_TOGGLE: nxt = ~pat;
         default:     nxt = pat;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/io_stim_sequencer_if.sv
// io_stim_sequencer_if: serial config pins, run level and pad bank outputs
// of the stimulus sequencer. The master side drives the serial pins and run,
// the slave side (the sequencer) drives the pad values and status flags.
// Optional macro STIM_READBACK_EN adds the rb_dat readback signal.
interface io_stim_sequencer_if;

   logic       ser_clk;
   logic       ser_dat;
   logic       ser_lat;
   logic       run;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       busy;
   logic       done;
   logic       err;
`ifdef STIM_READBACK_EN
   logic       rb_dat;
`endif

`ifdef STIM_READBACK_EN
   modport master (output ser_clk, ser_dat, ser_lat, run,
                   input  uio_out, uio_oe, busy, done, err, rb_dat);
   modport slave  (input  ser_clk, ser_dat, ser_lat, run,
                   output uio_out, uio_oe, busy, done, err, rb_dat);
`else
   modport master (output ser_clk, ser_dat, ser_lat, run,
                   input  uio_out, uio_oe, busy, done, err);
   modport slave  (input  ser_clk, ser_dat, ser_lat, run,
                   output uio_out, uio_oe, busy, done, err);
`endif

endinterface

// File: rtl/io_stim_sync_edge.sv
// io_stim_sync_edge: two-flop synchroniser for a pin that is asynchronous to
// clk, plus a history flop so a rising edge shows up as a one-cycle pulse.
// The pulse appears two clk edges after the pin rises and is consumed on the
// third, which gives the pin-to-register latency of three cycles.
module io_stim_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic [2:0] sync_q;

   // Shift the pin through two metastability flops and one history flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_i};
      end
   end

   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/io_stim_sequencer.sv
// io_stim_sequencer: drives the bidirectional pad bank of the analog test
// tile. A config word is shifted in serially into a shadow register, latched
// into the active config, then a pattern steps out at divider+1 clocks per
// step for a programmable number of steps (0 = free-run).
// Optional macro STIM_READBACK_EN presents shadow[23] on rb_dat.
module io_stim_sequencer
   import io_stim_pkg::*;
#(
   parameter int DIV_W = 8,
   parameter int CFG_W = io_stim_pkg::CFG_W
) (
   input logic               clk,
   input logic               rst,
   io_stim_sequencer_if.slave bus
);

   logic             datLevel;
   logic             datRise;
   logic             clkLevel;
   logic             clkRise;
   logic             latLevel;
   logic             latRise;

   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic             err_q, err_d;
   state_e           state_q, state_d;
   logic [7:0]       pat_q, pat_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [3:0]       step_q, step_d;

   logic [7:0]       oeMask;
   logic [DIV_W-1:0] divider;
   logic [3:0]       mode;
   logic [3:0]       steps;
   logic             live;

   io_stim_sync_edge uSyncDat (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.ser_dat),
      .level_o (datLevel),
      .rise_o  (datRise)
   );

   io_stim_sync_edge uSyncClk (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.ser_clk),
      .level_o (clkLevel),
      .rise_o  (clkRise)
   );

   io_stim_sync_edge uSyncLat (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.ser_lat),
      .level_o (latLevel),
      .rise_o  (latRise)
   );

   assign oeMask  = cfg_q[MASK_LSB +: 8];
   assign divider = DIV_W'(cfg_q[DIV_LSB +: 8]);
   assign mode    = cfg_q[MODE_LSB +: 4];
   assign steps   = cfg_q[STEPS_LSB +: 4];

   // Serial loader: shift first, then commit, so a latch that lands in the
   // same cycle as a shift captures the new bit. Latching while running is
   // refused and leaves a sticky error that only reset clears.
   always_comb begin
      shadow_d = shadow_q;
      cfg_d    = cfg_q;
      err_d    = err_q;
      if (clkRise) begin
         shadow_d = {shadow_q[CFG_W-2:0], datLevel};
      end
      if (latRise) begin
         if (state_q == RUN) begin
            err_d = 1'b1;
         end else begin
            cfg_d = shadow_d;
         end
      end
   end

   // Sequencer next state: IDLE keeps the seed ready, RUN steps the pattern
   // on prescaler terminal count and finishes on the last step, DONE freezes.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      presc_d = presc_q;
      step_d  = step_q;
      case (state_q)
         IDLE: begin
            pat_d   = modeSeed(mode);
            presc_d = '0;
            step_d  = 4'd0;
            if (bus.run) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.run) begin
               state_d = IDLE;
               presc_d = '0;
               step_d  = 4'd0;
            end else if (presc_q == divider) begin
               presc_d = '0;
               pat_d   = modeAdvance(mode, pat_q);
               step_d  = step_q + 4'd1;
               if ((steps != 4'd0) && (step_d == steps)) begin
                  state_d = DONE;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         DONE: begin
            if (!bus.run) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register all loader and sequencer state; reset clears config too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         cfg_q    <= '0;
         err_q    <= 1'b0;
         state_q  <= IDLE;
         pat_q    <= 8'h00;
         presc_q  <= '0;
         step_q   <= 4'd0;
      end else begin
         shadow_q <= shadow_d;
         cfg_q    <= cfg_d;
         err_q    <= err_d;
         state_q  <= state_d;
         pat_q    <= pat_d;
         presc_q  <= presc_d;
         step_q   <= step_d;
      end
   end

   assign live        = (state_q != IDLE);
   assign bus.uio_out = live ? (pat_q & oeMask) : 8'h00;
   assign bus.uio_oe  = live ? oeMask : 8'h00;
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.err     = err_q;
`ifdef STIM_READBACK_EN
   assign bus.rb_dat  = shadow_q[CFG_W-1];
`endif

endmodule
